rf_write_sched: RTL and testbench

Write-port scheduler and scoreboard for the 32x32 register file. It merges two writers onto the single register-file write port: the pipeline WB stage, which has fixed priority, and the multi-cycle multiply/divide unit (MDU), whose results pass through a small FIFO. A per-register busy scoreboard tracks MDU destinations still in flight. The block stalls the ID stage on RAW and WAW hazards against those registers and when MDU result storage is exhausted.

---
 rtl/rf_write_sched.sv | 155 +++++++++++++++
 tb/tb_rf_write_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: WB has priority, MDU results queue in a FIFO.
// Busy scoreboard tracks in-flight MDU destinations and drives the ID stall.
module rf_write_sched #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rs,
  input  logic [ADDR_W-1:0]        issue_rt,
  input  logic                     issue_we,
  input  logic                     issue_mdu,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     stall,
  input  logic                     wb_regwrite,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mdu_valid,
  input  logic [ADDR_W-1:0]        mdu_addr,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int NREG = 1 << ADDR_W;
  localparam int PW   = $clog2(BUF_DEPTH);
  localparam int CW   = $clog2(BUF_DEPTH + 1);
  localparam int OW   = $clog2(MAX_OUTST + 1);

  localparam logic [CW-1:0] CFULL = CW'(BUF_DEPTH);
  localparam logic [OW-1:0] OMAX  = OW'(MAX_OUTST);

  logic [ADDR_W-1:0] fa_q [BUF_DEPTH];
  logic [ADDR_W-1:0] fa_d [BUF_DEPTH];
  logic [DATA_W-1:0] fd_q [BUF_DEPTH];
  logic [DATA_W-1:0] fd_d [BUF_DEPTH];

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              wb_req;
  logic              acc;
  logic              push;
  logic              disc;
  logic              pop;
  logic              mdu_iss;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    wb_req    = wb_regwrite && (wb_addr != '0);
    mdu_ready = !reset && (count_q != CFULL);
    acc       = mdu_valid && mdu_ready;
    push      = acc && (mdu_addr != '0);
    disc      = acc && (mdu_addr == '0);
    pop       = !wb_req && (count_q != '0);
    head_addr = fa_q[rptr_q];
    head_data = fd_q[rptr_q];

    // A full FIFO stalls everything so bubbles let it drain past WB
    stall = issue_valid && (busy_q[issue_rs] || busy_q[issue_rt] ||
            (issue_we && busy_q[issue_rd]) ||
            (issue_mdu && (outst_q == OMAX)) ||
            (count_q == CFULL));
    mdu_iss = issue_valid && issue_mdu && !stall;
  end

  always_comb begin
    fa_d       = fa_q;
    fd_d       = fd_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (push) begin
      fa_d[wptr_q] = mdu_addr;
      fd_d[wptr_q] = mdu_data;
      wptr_d       = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    outst_d = outst_q + OW'(mdu_iss) - OW'(pop) - OW'(disc);

    if (wb_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end

    // Clear before set so a same-bit collision keeps the bit set
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (mdu_iss) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    fa_q <= fa_d;
    fd_q <= fd_d;
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_we;
  logic        issue_mdu;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        wb_regwrite;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  rf_write_sched dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_we(issue_we), .issue_mdu(issue_mdu), .issue_rd(issue_rd),
    .stall(stall),
    .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_we = 0;
    issue_mdu = 0; issue_rd = 0;
    wb_regwrite = 0; wb_addr = 0; wb_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
  endtask

  task automatic issue_mdu_op(input logic [4:0] rd);
    issue_valid = 1; issue_mdu = 1; issue_we = 1; issue_rd = rd;
    issue_rs = 0; issue_rt = 0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
    tests_run++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL rst_waddr got=%0d exp=0", rf_waddr); end
    tests_run++; if (rf_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", rf_wdata); end
    tests_run++; if (busy !== 32'd0) begin fails++; $display("FAIL rst_busy got=%h exp=0", busy); end
    tests_run++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%0b exp=1", mdu_ready); end
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0b exp=0", stall); end
  endtask

  task automatic test_wb_only;
    idle();
    wb_regwrite = 1; wb_addr = 8; wb_data = 32'hDEADBEEF;
    tick();
    tests_run++; if (rf_we !== 1'b1) begin fails++; $display("FAIL wb_we got=%0b exp=1", rf_we); end
    tests_run++; if (rf_waddr !== 5'd8) begin fails++; $display("FAIL wb_addr got=%0d exp=8", rf_waddr); end
    tests_run++; if (rf_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wb_data got=%h exp=deadbeef", rf_wdata); end
    wb_addr = 0; wb_data = 32'h1234;
    tick();
    tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL wb_r0_we got=%0b exp=0", rf_we); end
    tests_run++; if (rf_waddr !== 5'd8) begin fails++; $display("FAIL wb_hold_addr got=%0d exp=8", rf_waddr); end
    idle();
  endtask

  task automatic test_raw;
    idle();
    issue_mdu_op(3);
    #1;
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL raw_issue_stall got=%0b exp=0", stall); end
    tick();
    tests_run++; if (busy !== 32'h8) begin fails++; $display("FAIL raw_busy got=%h exp=8", busy); end
    issue_mdu = 0; issue_we = 0; issue_rd = 0; issue_rs = 3;
    mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h12;
    #1;
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall got=%0b exp=1", stall); end
    tests_run++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL raw_ready got=%0b exp=1", mdu_ready); end
    tick();
    mdu_valid = 0;
    #1;
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall_k1 got=%0b exp=1", stall); end
    tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL raw_we_k1 got=%0b exp=0", rf_we); end
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h12) begin
      fails++; $display("FAIL raw_commit got=%0b/%0d/%h exp=1/3/12", rf_we, rf_waddr, rf_wdata); end
    tests_run++; if (busy !== 32'd0) begin fails++; $display("FAIL raw_busy_clr got=%h exp=0", busy); end
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL raw_stall_k2 got=%0b exp=0", stall); end
    idle();
  endtask

  task automatic test_collision;
    idle();
    issue_mdu_op(5); tick();
    issue_mdu_op(6); tick();
    idle();
    mdu_valid = 1; mdu_addr = 5; mdu_data = 32'hAA;
    tick();
    mdu_addr = 6; mdu_data = 32'hBB;
    wb_regwrite = 1; wb_addr = 7; wb_data = 32'h70;
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h70) begin
      fails++; $display("FAIL col_k2 got=%0b/%0d/%h exp=1/7/70", rf_we, rf_waddr, rf_wdata); end
    mdu_valid = 0; wb_data = 32'h71;
    issue_valid = 1; issue_rs = 1; issue_rt = 2;
    #1;
    tests_run++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL col_full_ready got=%0b exp=0", mdu_ready); end
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL col_full_stall got=%0b exp=1", stall); end
    tick();
    issue_valid = 0;
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h71) begin
      fails++; $display("FAIL col_k3 got=%0b/%0d/%h exp=1/7/71", rf_we, rf_waddr, rf_wdata); end
    wb_data = 32'h72;
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h72) begin
      fails++; $display("FAIL col_k4 got=%0b/%0d/%h exp=1/7/72", rf_we, rf_waddr, rf_wdata); end
    wb_regwrite = 0;
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hAA) begin
      fails++; $display("FAIL col_k5 got=%0b/%0d/%h exp=1/5/aa", rf_we, rf_waddr, rf_wdata); end
    tests_run++; if (busy !== 32'h40) begin fails++; $display("FAIL col_busy_k5 got=%h exp=40", busy); end
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'hBB) begin
      fails++; $display("FAIL col_k6 got=%0b/%0d/%h exp=1/6/bb", rf_we, rf_waddr, rf_wdata); end
    tests_run++; if (busy !== 32'd0) begin fails++; $display("FAIL col_busy_k6 got=%h exp=0", busy); end
    idle();
    tick();
  endtask

  task automatic test_limits;
    logic [4:0] rds [4];
    rds[0] = 10; rds[1] = 11; rds[2] = 12; rds[3] = 0;
    idle();
    for (int i = 0; i < 4; i++) begin
      issue_mdu_op(rds[i]);
      #1;
      tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL lim_issue%0d got=%0b exp=0", i, stall); end
      tick();
    end
    issue_mdu_op(13);
    #1;
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL lim_max_stall got=%0b exp=1", stall); end
    idle();
    mdu_valid = 1; mdu_addr = 0; mdu_data = 32'h55;
    tick();
    mdu_valid = 0;
    tick();
    tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL lim_r0_we got=%0b exp=0", rf_we); end
    tests_run++; if (busy !== 32'h1C00) begin fails++; $display("FAIL lim_r0_busy got=%h exp=1c00", busy); end
    issue_mdu_op(13);
    #1;
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL lim_after_disc got=%0b exp=0", stall); end
    tick();
    idle();
    for (int i = 10; i < 14; i++) begin
      mdu_valid = 1; mdu_addr = 5'(i); mdu_data = 32'(i);
      tick();
    end
    idle();
    tick(); tick();
    tests_run++; if (busy !== 32'd0) begin fails++; $display("FAIL lim_drain_busy got=%h exp=0", busy); end
  endtask

  task automatic test_waw;
    idle();
    issue_mdu_op(9);
    tick();
    tests_run++; if (busy !== 32'h200) begin fails++; $display("FAIL waw_busy got=%h exp=200", busy); end
    issue_mdu = 0; issue_we = 1; issue_rd = 9; issue_rs = 1; issue_rt = 2;
    #1;
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_stall got=%0b exp=1", stall); end
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
    tick();
    mdu_valid = 0;
    #1;
    tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_stall_k1 got=%0b exp=1", stall); end
    tick();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
      fails++; $display("FAIL waw_commit got=%0b/%0d/%h exp=1/9/99", rf_we, rf_waddr, rf_wdata); end
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL waw_stall_k2 got=%0b exp=0", stall); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid;
    idle();
    issue_mdu_op(2); tick();
    issue_mdu_op(8); tick();
    idle();
    tests_run++; if (busy !== 32'h104) begin fails++; $display("FAIL rm_busy_pre got=%h exp=104", busy); end
    wb_regwrite = 1; wb_addr = 1; wb_data = 1;
    mdu_valid = 1; mdu_addr = 2; mdu_data = 32'h22;
    tick();
    mdu_addr = 8; mdu_data = 32'h88;
    tick();
    idle();
    reset = 1;
    #1;
    tests_run++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL rm_ready_in_rst got=%0b exp=0", mdu_ready); end
    tick();
    tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rm_we got=%0b exp=0", rf_we); end
    tests_run++; if (busy !== 32'd0) begin fails++; $display("FAIL rm_busy got=%h exp=0", busy); end
    tests_run++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL rm_ready_hold got=%0b exp=0", mdu_ready); end
    reset = 0;
    #1;
    tests_run++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL rm_ready_after got=%0b exp=1", mdu_ready); end
    for (int i = 0; i < 4; i++) begin
      issue_mdu_op(0);
      #1;
      tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL rm_outst_issue%0d got=%0b exp=0", i, stall); end
      tick();
    end
    idle();
  endtask

  task automatic test_random;
    ent_t        q[$];
    logic [4:0]  pend[$];
    logic [31:0] mb;
    int          outst;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          mv_act;
    logic [4:0]  mv_a;
    logic [31:0] mv_d;
    bit          s_m;
    bit          r_m;
    ent_t        e;
    idle();
    reset = 1;
    tick();
    reset = 0;
    mb = 0; outst = 0; ewe = 0; ea = 0; ed = 0; mv_act = 0; mv_a = 0; mv_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!mv_act && pend.size() > 0 && $urandom_range(1, 0) == 1) begin
        mv_act = 1; mv_a = pend.pop_front(); mv_d = $urandom;
      end
      issue_valid = $urandom_range(1, 0) == 1;
      issue_rs = 5'($urandom_range(12, 0));
      issue_rt = 5'($urandom_range(12, 0));
      issue_rd = 5'($urandom_range(12, 0));
      issue_mdu = $urandom_range(2, 0) == 0;
      issue_we = issue_mdu || ($urandom_range(1, 0) == 1);
      wb_regwrite = $urandom_range(2, 0) == 0;
      wb_addr = 5'($urandom_range(12, 0));
      wb_data = $urandom;
      mdu_valid = mv_act; mdu_addr = mv_a; mdu_data = mv_d;
      #1;
      s_m = issue_valid && (mb[issue_rs] || mb[issue_rt] || (issue_we && mb[issue_rd]) ||
            (issue_mdu && outst == 4) || q.size() == 2);
      r_m = q.size() < 2;
      tests_run++; if (stall !== s_m) begin fails++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall, s_m); end
      tests_run++; if (mdu_ready !== r_m) begin fails++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, mdu_ready, r_m); end
      if (wb_regwrite && wb_addr != 0) begin
        ewe = 1; ea = wb_addr; ed = wb_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        ewe = 1; ea = e.a; ed = e.d; mb[e.a] = 0; outst--;
      end else begin
        ewe = 0;
      end
      if (mv_act && r_m) begin
        if (mv_a == 0) outst--;
        else q.push_back(ent_t'{a: mv_a, d: mv_d});
        mv_act = 0;
      end
      if (issue_valid && issue_mdu && !s_m) begin
        outst++;
        pend.push_back(issue_rd);
        if (issue_rd != 0) mb[issue_rd] = 1;
      end
      tick();
      tests_run++; if (rf_we !== ewe || rf_waddr !== ea || rf_wdata !== ed) begin
        fails++; $display("FAIL rnd_rf c=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, ewe, ea, ed); end
      tests_run++; if (busy !== mb) begin fails++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy, mb); end
    end
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_wb_only();
    test_raw();
    test_collision();
    test_limits();
    test_waw();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
